// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Oversampling asynchronous-serial frame receiver. Validates the start bit at
//   mid-bit, assembles DATA_BITS data bits LSB-first, optionally checks a parity
//   bit, checks one or two stop bits, and delivers each frame through a
//   valid/ready holding register carrying framing, parity and overrun flags.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   UART_RX      serial line, idle high, asynchronous to clk
//   RX_Ready     consumer accepts RX_Data when high together with RX_Valid
//   RX_Data      payload of the last committed frame
//   RX_Valid     RX_Data holds an unconsumed frame
//   RX_Status    one-cycle pulse per committed frame
//   RX_FrameErr  a stop bit of the held frame sampled 0
//   RX_ParityErr parity mismatch on the held frame
//   RX_Overrun   held frame overwrote an unconsumed one

module uart_frame_rx #(
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 UART_RX,
    input  logic                 RX_Ready,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Valid,
    output logic                 RX_Status,
    output logic                 RX_FrameErr,
    output logic                 RX_ParityErr,
    output logic                 RX_Overrun
);

    localparam int unsigned CntW    = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW    = $clog2(DATA_BITS + 3);
    localparam int unsigned ParBits = (PARITY_EN != 0) ? 1 : 0;
    // Bit index of the final stop-bit sample (data, parity and stop share idx).
    localparam int unsigned LastIdx = DATA_BITS + ParBits + STOP_BITS - 1;

    localparam logic [CntW-1:0] HalfM1    = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] FullM1    = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] DataLast  = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] FrameLast = IdxW'(LastIdx);
    localparam logic            ParOdd    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    // Two-flop synchronizer, preset to the idle line level.
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_q, perr_d;
    logic                   commit_q, commit_d;

    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   status_q, status_d;
    logic                   fe_q, fe_d;
    logic                   pe_q, pe_d;
    logic                   ovr_q, ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            commit_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            status_q <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            commit_q <= commit_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            status_q <= status_d;
            fe_q     <= fe_d;
            pe_q     <= pe_d;
            ovr_q    <= ovr_d;
        end
    end

    // Receive FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        commit_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end

            StStart: begin
                if (cnt_q == HalfM1) begin
                    if (rx_s_q) begin
                        state_d = StIdle;  // false start (glitch)
                    end else begin
                        state_d = StData;
                        cnt_d   = '0;
                        idx_d   = '0;
                        ferr_d  = 1'b0;
                        perr_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StData: begin
                if (cnt_q == FullM1) begin
                    cnt_d = '0;
                    for (int i = 0; i < int'(DATA_BITS); i++) begin
                        if (idx_q == IdxW'(i)) begin
                            shift_d[i] = rx_s_q;
                        end
                    end
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == DataLast) begin
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StParity: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    perr_d  = ((^shift_q) ^ rx_s_q) != ParOdd;
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StStop: begin
                if (cnt_q == FullM1) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end
                    if (idx_q == FrameLast) begin
                        commit_d = 1'b1;
                        // A low stop bit may be a break; wait for the line to
                        // recover before accepting another start.
                        state_d  = (ferr_q || !rx_s_q) ? StBrkWait : StIdle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StBrkWait: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Holding register and handshake
    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        status_d = 1'b0;
        fe_d     = fe_q;
        pe_d     = pe_q;
        ovr_d    = ovr_q;

        if (commit_q) begin
            data_d   = shift_q;
            fe_d     = ferr_q;
            pe_d     = perr_q;
            valid_d  = 1'b1;
            status_d = 1'b1;
            // Overrun only when an unconsumed frame is being replaced.
            ovr_d    = valid_q && !RX_Ready;
        end else if (valid_q && RX_Ready) begin
            valid_d = 1'b0;
        end
    end

    assign RX_Data      = data_q;
    assign RX_Valid     = valid_q;
    assign RX_Status    = status_q;
    assign RX_FrameErr  = fe_q;
    assign RX_ParityErr = pe_q;
    assign RX_Overrun   = ovr_q;

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Parametrised asynchronous-serial frame receiver. It is the successor of the fixed 12-bit deserializer in the FSK receive path. It oversamples the demodulated UART_RX line and validates the start bit mid-bit. It assembles DATA_BITS data bits LSB-first, with optional parity and one or two stop bits. Each frame is delivered through a valid/ready holding register with framing, parity and overrun flags.

Parameters:
DATA_BITS, 12, data bits per frame (1..32)
OVERSAMPLE, 16, clk cycles per bit period (even, >=4)
PARITY_EN, 0, 1 = parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
UART_RX  in  1  serial line, idle high, asynchronous to clk
RX_Ready  in  1  consumer accepts RX_Data when high with RX_Valid
RX_Data  out  DATA_BITS  last committed frame payload
RX_Valid  out  1  RX_Data holds an unconsumed frame
RX_Status  out  1  one-cycle pulse per committed frame (legacy strobe)
RX_FrameErr  out  1  a stop bit of the held frame sampled 0
RX_ParityErr  out  1  parity mismatch on the held frame (always 0 if PARITY_EN=0)
RX_Overrun  out  1  held frame overwrote an unconsumed one

Behaviour:
- Reset (asynchronous, active-high):
  - all outputs 0, FSM to IDLE, counters 0.
  - The 2-flop UART_RX synchronizer presets to 1 (idle line).
  - Reset mid-frame discards the partial frame; no commit.
- All FSM decisions use the synchronised rx_s. rx_s lags UART_RX by 2 clk.
- Counter widths: bit counter is clog2(OVERSAMPLE) bits; bit index covers DATA_BITS+2.
- FSM states:
  - IDLE: rx_s==0 -> START, cnt<=0.
  - START: cnt increments. At cnt==OVERSAMPLE/2-1:
    - rx_s==1 -> false start, back to IDLE; no flags change.
    - rx_s==0 -> DATA, cnt<=0, idx<=0.
  - DATA: at cnt==OVERSAMPLE-1:
    - shift rx_s in LSB-first (first received bit -> RX_Data[0]); cnt<=0; idx++.
    - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - PARITY: at cnt==OVERSAMPLE-1, sample the parity bit.
    - Error if XOR(data, parity bit) != PARITY_ODD.
    - Then -> STOP.
  - STOP: at cnt==OVERSAMPLE-1, sample; any 0 sets the frame-error bit.
    - After STOP_BITS samples, commit on the next edge.
    - Then -> IDLE if no framing error, else -> BRK_WAIT.
  - BRK_WAIT: stay until rx_s==1, then -> IDLE. Prevents a break or low line from re-triggering a start.
- Timing:
  - Start is detected at edge D.
  - Data bit k is sampled at D+OVERSAMPLE/2+OVERSAMPLE*(k+1).
  - With defaults, the single stop bit is sampled at D+216.
  - Commit (RX_Valid rise, RX_Status pulse) is at D+217.
- Commit: RX_Data, RX_FrameErr and RX_ParityErr load together; RX_Status=1 for exactly one cycle.
- Handshake:
  - RX_Valid stays high until a cycle with RX_Valid && RX_Ready; it clears on the following edge.
  - Data and flags are stable while RX_Valid=1 and no commit occurs.
- Simultaneous events:
  - Commit with RX_Ready && RX_Valid: old frame consumed, new frame loaded, RX_Valid stays 1, RX_Overrun<=0.
  - Commit with RX_Valid && !RX_Ready: new frame overwrites, RX_Overrun<=1.
  - Commit with RX_Valid=0: RX_Overrun<=0.
- The receiver never stalls: reception continues regardless of RX_Ready.

Test Plan:
- Defaults, RX_Ready=1: send 12'hA5C at 16 clk/bit, stop=1 -> RX_Data=12'hA5C at D+217; RX_Valid and RX_Status high one cycle; all error flags 0.
- 6-clk low glitch on idle line -> FSM returns to IDLE at mid-start; no RX_Status; RX_Valid stays 0.
- Defaults, stop bit driven 0 for frame 12'h0FF, then line held low 100 clk -> RX_FrameErr=1, RX_Data=12'h0FF; no second frame until line returns high, then 12'h123 is received cleanly.
- DATA_BITS=8, PARITY_EN=1, PARITY_ODD=0: send 8'h07 with parity 1 -> RX_ParityErr=0; send 8'h07 with parity 0 -> RX_ParityErr=1.
- RX_Ready=0, two back-to-back frames 12'h111 then 12'h222 -> after the second commit RX_Data=12'h222, RX_Overrun=1, RX_Valid=1. Assert RX_Ready one cycle -> RX_Valid=0 next edge.
- Assert rst at D+100 mid-frame, release, then send 12'h3C3 -> no commit from the aborted frame; RX_Data=12'h3C3 with clean flags.
